// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and counter-width helper for the debounce bank
package debounce_pkg;

    // Board runs at 25 MHz: 10 ms debounce window, 1 s long-press.
    localparam int BOARD_CLK_HZ           = 25_000_000;
    localparam int DEFAULT_DEBOUNCE_LIMIT = BOARD_CLK_HZ / 100;
    localparam int DEFAULT_HOLD_LIMIT     = BOARD_CLK_HZ;

    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// rtl/debounce_bank_if.sv - raw switch inputs and conditioned outputs of the debounce bank
interface debounce_bank_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] sw_i;
    logic [NUM_CH-1:0] sw_o;
    logic [NUM_CH-1:0] rise_o;
    logic [NUM_CH-1:0] fall_o;
    logic [NUM_CH-1:0] hold_o;
    logic              any_edge_o;

    modport master (
        output sw_i,
        input  sw_o, rise_o, fall_o, hold_o, any_edge_o
    );

    modport slave (
        input  sw_i,
        output sw_o, rise_o, fall_o, hold_o, any_edge_o
    );
endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one switch: synchroniser, stability counter, edge and long-press pulses
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int HOLD_LIMIT     = DEFAULT_HOLD_LIMIT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_hold,
    output logic o_edge_nxt
);

    localparam int DB_W = cnt_width(DEBOUNCE_LIMIT);
    localparam int HB_W = cnt_width(HOLD_LIMIT + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HOLD_LIMIT - 1);
    localparam logic [HB_W-1:0] HB_FULL = HB_W'(HOLD_LIMIT);

    logic            r_meta;
    logic            r_sync;
    logic            r_state;
    logic [DB_W-1:0] r_cnt;
    logic            r_rise;
    logic            r_fall;
    logic            r_hold;
    logic [HB_W-1:0] r_hcnt;
    logic            r_held;

    logic w_diff;
    logic w_flip;
    logic w_state_nxt;
    logic w_hold_hit;

    assign w_diff      = r_sync ^ r_state;
    assign w_flip      = w_diff && (r_cnt == DB_LAST);
    assign w_state_nxt = r_state ^ w_flip;
    // A release on the very cycle the hold count completes suppresses the hold pulse.
    assign w_hold_hit  = r_state && w_state_nxt && !r_held && (r_hcnt == HB_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_state <= 1'b0;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_hold  <= 1'b0;
            r_hcnt  <= '0;
            r_held  <= 1'b0;
        end else begin
            r_meta  <= i_sw;
            r_sync  <= r_meta;
            r_state <= w_state_nxt;
            r_rise  <= w_flip && !r_state;
            r_fall  <= w_flip && r_state;
            r_hold  <= w_hold_hit;

            if (!w_diff || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DB_W'(1);
            end

            if (!w_state_nxt) begin
                r_hcnt <= '0;
                r_held <= 1'b0;
            end else if (r_state && !r_held) begin
                if (w_hold_hit) begin
                    r_hcnt <= HB_FULL;
                    r_held <= 1'b1;
                end else begin
                    r_hcnt <= r_hcnt + HB_W'(1);
                end
            end
        end
    end

    assign o_level    = r_state;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;
    assign o_hold     = r_hold;
    assign o_edge_nxt = w_flip;

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - NUM_CH independent debounce channels plus a registered any-edge flag
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int HOLD_LIMIT     = DEFAULT_HOLD_LIMIT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    debounce_bank_if.slave  bus
);

    logic [NUM_CH-1:0] w_edge_nxt;
    logic              r_any_edge;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
                .HOLD_LIMIT     (HOLD_LIMIT)
            ) u_ch (
                .i_clk      (clk_i),
                .i_rst      (rst_i),
                .i_sw       (bus.sw_i[g]),
                .o_level    (bus.sw_o[g]),
                .o_rise     (bus.rise_o[g]),
                .o_fall     (bus.fall_o[g]),
                .o_hold     (bus.hold_o[g]),
                .o_edge_nxt (w_edge_nxt[g])
            );
        end
    endgenerate

    // Built from the channels' next-cycle flips so it lines up with rise_o/fall_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_any_edge <= 1'b0;
        end else begin
            r_any_edge <= |w_edge_nxt;
        end
    end

    assign bus.any_edge_o = r_any_edge;

endmodule
